// File: rtl/multi_rate_divider_pkg.sv
// Shared constants and helpers for the multi-channel rate divider.
package multi_rate_divider_pkg;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

  // Channel-select width; a single channel still needs one select bit.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multi_rate_divider_if.sv
// Period/mode write port shared by all channels of the divider.
interface multi_rate_divider_if
  import multi_rate_divider_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 32
);
  localparam int CH_W = ch_width(NUM_CH);

  logic             wr_en;
  logic [CH_W-1:0]  wr_ch;
  logic [WIDTH-1:0] wr_period;
  logic             wr_mode;
  logic             wr_restart;

  modport master (output wr_en, wr_ch, wr_period, wr_mode, wr_restart);
  modport slave  (input  wr_en, wr_ch, wr_period, wr_mode, wr_restart);
endinterface

// File: rtl/multi_rate_divider_rate_channel.sv
// One down-counting channel: period/mode registers, live count, tick and
// sticky one-shot done flag.
module rate_channel
  import multi_rate_divider_pkg::*;
#(
  parameter int               WIDTH          = 32,
  parameter logic [WIDTH-1:0] DEFAULT_PERIOD = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_stb_i,
  input  logic [WIDTH-1:0] wr_period_i,
  input  logic             wr_mode_i,
  input  logic             wr_restart_i,
  input  logic             enable_i,
  output logic             tick_o,
  output logic             done_o,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] count_q,  count_d;
  logic [WIDTH-1:0] reload;
  logic             mode_q,   mode_d;
  logic             tick_q,   tick_d;
  logic             done_q,   done_d;

  // Next-state: restart write > disable > frozen one-shot > terminal > decrement.
  always_comb begin
    period_d = period_q;
    mode_d   = mode_q;
    count_d  = count_q;
    tick_d   = 1'b0;
    done_d   = done_q;
    // A write landing on a reload edge must reload the new period.
    reload   = wr_stb_i ? wr_period_i : period_q;

    if (wr_stb_i) begin
      period_d = wr_period_i;
      mode_d   = wr_mode_i;
    end

    if (wr_stb_i && wr_restart_i) begin
      count_d = wr_period_i;
      done_d  = 1'b0;
    end else if (!enable_i) begin
      count_d = reload;
      done_d  = 1'b0;
    end else if (mode_q == MODE_ONESHOT && done_q) begin
      // Fired one-shot: count stays frozen until re-armed.
      count_d = count_q;
    end else if (count_q == '0) begin
      count_d = reload;
      tick_d  = 1'b1;
      if (mode_q == MODE_ONESHOT) done_d = 1'b1;
    end else begin
      count_d = count_q - WIDTH'(1);
    end

    // Any write re-arms the channel, including a non-restarting one.
    if (wr_stb_i && !wr_restart_i) done_d = 1'b0;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      period_q <= DEFAULT_PERIOD;
      mode_q   <= MODE_PERIODIC;
      count_q  <= DEFAULT_PERIOD;
      tick_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      period_q <= period_d;
      mode_q   <= mode_d;
      count_q  <= count_d;
      tick_q   <= tick_d;
      done_q   <= done_d;
    end
  end

  assign tick_o  = tick_q;
  assign done_o  = done_q;
  assign count_o = count_q;

endmodule

// File: rtl/multi_rate_divider.sv
// NUM_CH independent programmable rate dividers behind one write port.
module multi_rate_divider
  import multi_rate_divider_pkg::*;
#(
  parameter int               NUM_CH         = 4,
  parameter int               WIDTH          = 32,
  parameter logic [WIDTH-1:0] DEFAULT_PERIOD = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  multi_rate_divider_if.slave     wr,
  input  logic [NUM_CH-1:0]       ch_enable,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       done,
  output logic [NUM_CH*WIDTH-1:0] count
);

  // Write decode: selects that match no channel fall through as no-ops.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wr_stb;
    assign wr_stb = wr.wr_en && (32'(wr.wr_ch) == i);

    rate_channel #(
      .WIDTH          (WIDTH),
      .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .wr_stb_i     (wr_stb),
      .wr_period_i  (wr.wr_period),
      .wr_mode_i    (wr.wr_mode),
      .wr_restart_i (wr.wr_restart),
      .enable_i     (ch_enable[i]),
      .tick_o       (tick[i]),
      .done_o       (done[i]),
      .count_o      (count[i*WIDTH +: WIDTH])
    );
  end

endmodule

// File: doc/multi_rate_divider.md
Name: multi_rate_divider

Overview:
Parametrised, multi-channel successor to the single down-counting rate divider. Holds NUM_CH independent down-counters, each with its own programmable period, periodic/one-shot mode and one-cycle tick output. Sits between the system clock and the plotting/animation logic, which needs several unrelated update rates from one clock (pixel step, redraw, blink). Periods are programmed at run time through a single write port.

Parameters:
NUM_CH, 4, number of independent channels (>=1)
WIDTH, 32, counter and period width in bits
DEFAULT_PERIOD, 0, period loaded into every channel at reset
CH_W (localparam), max(1, clog2(NUM_CH)), channel-select width

Ports:
clk  in  1  system clock; one clock; reset is synchronous and active-high
reset  in  1  synchronous, active-high; sampled on rising edge of clk
wr_en  in  1  write strobe for the period/mode register of wr_ch
wr_ch  in  CH_W  target channel; values >= NUM_CH ignored
wr_period  in  WIDTH  new period P; tick spacing is P+1 cycles
wr_mode  in  1  0 = periodic, 1 = one-shot
wr_restart  in  1  1 = reload counter immediately with wr_period
ch_enable  in  NUM_CH  per-channel run enable, level-sensitive
tick  out  NUM_CH  registered one-cycle pulse per channel at terminal count
done  out  NUM_CH  one-shot channel has fired, sticky
count  out  NUM_CH*WIDTH  live counter values, channel i at bits [i*WIDTH +: WIDTH]

Behaviour:
- Reset, dominant over all other inputs: period[i] = DEFAULT_PERIOD, mode[i] = periodic, count[i] = DEFAULT_PERIOD, tick = 0, done = 0.
- Per-channel priority on each rising edge, highest first:
  1. reset.
  2. Write with wr_restart=1: count <= wr_period, tick <= 0, done <= 0.
  3. ch_enable=0: count <= period, tick <= 0, done <= 0.
  4. One-shot with done=1: count holds, tick <= 0.
  5. count==0: count <= period, tick <= 1; if one-shot, done <= 1.
  6. Otherwise: count <= count-1, tick <= 0.
- Write to channel i: period[i] <= wr_period and mode[i] <= wr_mode in the same edge.
  - With wr_restart=0: count is untouched, the new period takes effect at the next reload, and done[i] is cleared.
- Tick spacing: with period P and enable held high, tick pulses are exactly P+1 cycles apart.
  - First tick occurs P+1 edges after enable rises, since count sits at P while disabled.
  - P=0 gives tick high every cycle (periodic mode).
- Terminal count and write on the same edge:
  - wr_restart=0: tick still fires, and the reload uses the NEW period (write-through to the reload value).
  - wr_restart=1: the tick is suppressed.
- One-shot: exactly one tick, then the counter freezes at period with done=1. Re-arm by any write to the channel or by toggling enable low.
- Counter arithmetic is unsigned modulo 2^WIDTH. Decrement never occurs at 0, so no underflow.
- Writes with wr_ch >= NUM_CH are no-ops. Channels are fully independent; no cross-channel interaction.
- Reset mid-count: the next cycle shows reset values, with no residual tick.

Decomposition:
- Package multi_rate_divider_pkg holds MODE_PERIODIC=1'b0 and MODE_ONESHOT=1'b1.
- Sub-module rate_channel holds one channel's period, mode, count, tick and done, with a per-channel write strobe (wr_en && wr_ch==i).
- Top level holds write decode and a generate loop over NUM_CH.

Test Plan:
- Reset, then ch_enable=0001 with default period 0 -> tick[0] high every cycle; count[0] stays 0; other ticks 0.
- Write ch1 P=4 periodic, restart=1, then enable ch1 -> ticks on ch1 exactly 5 cycles apart, count sequence 4,3,2,1,0,4.
- Write ch2 P=2 one-shot, restart=1, enable -> single tick after 3 cycles, done[2]=1, count frozen at 2. Rewrite ch2 -> done clears and the channel fires again once.
- Ch1 running P=4; write P=1, restart=0, mid-count -> current cycle completes at 5 cycles, then spacing becomes 2. Same write landing on the count==0 edge -> tick fires, reload value is 1.
- Drop ch_enable[1] mid-count (count=2) -> count reloads to period next edge, no tick. Assert reset mid-count -> all outputs at reset values on the next edge.
- Write with wr_ch=NUM_CH (for NUM_CH=4, wr_ch=3 after setting NUM_CH=3 in an alternate build) -> no channel changes.
